// File: rtl/haar_stage_scheduler.sv
// haar_stage_scheduler
//
// Sequences the stages of a Haar cascade for one detection window. For each
// stage it pulses a one-hot read enable to that stage's database reader. It
// waits for the reader's end-of-database flag and then for the stage
// pass/fail result. It either moves on to the next stage or finishes. A
// saturating per-stage timer turns a stalled stage into a timed-out
// evaluation.
//
// Ports
//   clk_fpga        in   clock, rising edge
//   reset_fpga      in   asynchronous reset, active low
//   i_start         in   request evaluation of one window (accepted in idle only)
//   i_abort         in   cancel the evaluation in progress
//   i_end_database  in   per-stage end-of-database flags [NUM_STAGES]
//   i_stage_valid   in   stage result valid
//   i_stage_pass    in   stage result, 1 = pass (qualified by i_stage_valid)
//   o_rden          out  one-hot read-enable pulse per stage [NUM_STAGES]
//   o_stage         out  active / last evaluated stage index [STAGE_WIDTH]
//   o_busy          out  high whenever not idle
//   o_done          out  one-cycle pulse at the end of an evaluation
//   o_face          out  all stages passed
//   o_timeout       out  last evaluation ended by timeout
module haar_stage_scheduler #(
  parameter int unsigned NUM_STAGES     = 8,
  parameter int unsigned STAGE_WIDTH    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4095
) (
  input  logic                   clk_fpga,
  input  logic                   reset_fpga,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [NUM_STAGES-1:0]  i_end_database,
  input  logic                   i_stage_valid,
  input  logic                   i_stage_pass,
  output logic [NUM_STAGES-1:0]  o_rden,
  output logic [STAGE_WIDTH-1:0] o_stage,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_face,
  output logic                   o_timeout
);

  localparam int unsigned TimerWidth = 12;
  localparam logic [TimerWidth-1:0] TimerMax  = TimerWidth'(TIMEOUT_CYCLES);
  // The deadline fires in the cycle whose increment makes the timer reach
  // TIMEOUT_CYCLES, so a stage gets exactly TIMEOUT_CYCLES wait cycles.
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(TIMEOUT_CYCLES - 1);
  localparam logic [STAGE_WIDTH-1:0] LastStage = STAGE_WIDTH'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitEnd,
    StWaitResult,
    StDone
  } state_e;

  state_e                 r_state;
  logic [NUM_STAGES-1:0]  r_rden;
  logic [STAGE_WIDTH-1:0] r_stage;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_face;
  logic                   r_timeout;
  logic [TimerWidth-1:0]  r_timer;

  logic [STAGE_WIDTH-1:0] w_stage_next;
  logic [NUM_STAGES-1:0]  w_cur_onehot;
  logic [NUM_STAGES-1:0]  w_next_onehot;
  logic                   w_end_hit;
  logic                   w_deadline;
  logic [TimerWidth-1:0]  w_timer_inc;

  assign w_stage_next  = r_stage + 1'b1;
  assign w_cur_onehot  = NUM_STAGES'(1) << r_stage;
  assign w_next_onehot = NUM_STAGES'(1) << w_stage_next;
  // Only the active stage's end flag matters; the others are masked off.
  assign w_end_hit     = |(i_end_database & w_cur_onehot);
  assign w_deadline    = (r_timer >= TimerLast);
  assign w_timer_inc   = (r_timer == TimerMax) ? r_timer : r_timer + 1'b1;

  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      r_state   <= StIdle;
      r_rden    <= '0;
      r_stage   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_face    <= 1'b0;
      r_timeout <= 1'b0;
      r_timer   <= '0;
    end else begin
      // Pulse outputs default low; only the transitions below raise them.
      r_rden <= '0;
      r_done <= 1'b0;

      if (r_state != StIdle && i_abort) begin
        // Abort beats every other transition; o_timeout is left untouched.
        r_state <= StIdle;
        r_busy  <= 1'b0;
        r_face  <= 1'b0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (i_start) begin
              r_state   <= StIssue;
              r_busy    <= 1'b1;
              r_stage   <= '0;
              r_rden    <= NUM_STAGES'(1);
              r_face    <= 1'b0;
              r_timeout <= 1'b0;
            end
          end

          StIssue: begin
            r_timer <= '0;
            r_state <= StWaitEnd;
          end

          StWaitEnd: begin
            r_timer <= w_timer_inc;
            // End flag on the deadline cycle still wins over the timeout.
            if (w_end_hit) begin
              r_state <= StWaitResult;
            end else if (w_deadline) begin
              r_state   <= StDone;
              r_done    <= 1'b1;
              r_timeout <= 1'b1;
              r_face    <= 1'b0;
            end
          end

          StWaitResult: begin
            r_timer <= w_timer_inc;
            if (i_stage_valid) begin
              if (!i_stage_pass) begin
                // Rejected: o_stage keeps the rejecting stage.
                r_state <= StDone;
                r_done  <= 1'b1;
                r_face  <= 1'b0;
              end else if (r_stage == LastStage) begin
                r_state <= StDone;
                r_done  <= 1'b1;
                r_face  <= 1'b1;
              end else begin
                // Raise the next read enable directly so it appears one
                // cycle after the result.
                r_state <= StIssue;
                r_stage <= w_stage_next;
                r_rden  <= w_next_onehot;
              end
            end else if (w_deadline) begin
              r_state   <= StDone;
              r_done    <= 1'b1;
              r_timeout <= 1'b1;
              r_face    <= 1'b0;
            end
          end

          StDone: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end

          default: begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_rden    = r_rden;
  assign o_stage   = r_stage;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_face    = r_face;
  assign o_timeout = r_timeout;

endmodule
